// File: rtl/tls_pkg.sv
// -----------------------------------------------------------------------------
// tls_pkg
// Shared definitions for the multi-approach traffic-light sequencer:
//   - tls_state_e : phase of the approach holding right-of-way
//   - LAMP_*      : lamp-vector helper constants (sliced to NUM_DIR by users)
//   - eff_dur()   : effective duration of a phase, applying the zero rules
// -----------------------------------------------------------------------------
package tls_pkg;

    typedef enum logic [1:0] {
        ST_GREEN  = 2'd0,
        ST_YELLOW = 2'd1,
        ST_ALLRED = 2'd2
    } tls_state_e;

    // Widest supported intersection; lamp constants are sliced down to NUM_DIR.
    localparam int MAX_DIR = 8;

    // Working width of eff_dur(); callers cast their TW-bit registers up to it.
    localparam int DUR_W = 32;

    localparam logic [MAX_DIR-1:0] LAMP_NONE  = 8'h00;
    localparam logic [MAX_DIR-1:0] LAMP_ALL   = 8'hFF;
    localparam logic [MAX_DIR-1:0] LAMP_FIRST = 8'h01;

    // Green and yellow never last less than one cycle. A zero all-red value
    // means the phase is skipped, so ALLRED is never occupied with ar == 0;
    // the floor of 1 there only keeps the compare well defined.
    function automatic logic [DUR_W-1:0] eff_dur(
        input tls_state_e       st,
        input logic [DUR_W-1:0] g,
        input logic [DUR_W-1:0] y,
        input logic [DUR_W-1:0] ar
    );
        logic [DUR_W-1:0] d;
        case (st)
            ST_GREEN:  d = (g  == 32'd0) ? 32'd1 : g;
            ST_YELLOW: d = (y  == 32'd0) ? 32'd1 : y;
            ST_ALLRED: d = (ar == 32'd0) ? 32'd1 : ar;
            default:   d = 32'd1;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/tls_phase_timer.sv
// -----------------------------------------------------------------------------
// tls_phase_timer
// 1-based phase counter for the traffic-light sequencer.
// Ports:
//   clk, rst      : clock, synchronous active-high reset (count -> 1)
//   restart       : force count to 1 on the next edge (set / jump)
//   hold          : freeze the counter (stop)
//   dur [TW]      : effective duration of the current phase (never 0)
//   count [TW]    : registered phase counter
//   phase_end     : count has reached the current duration
// -----------------------------------------------------------------------------
module tls_phase_timer #(
    parameter int TW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          restart,
    input  logic          hold,
    input  logic [TW-1:0] dur,
    output logic [TW-1:0] count,
    output logic          phase_end
);

    logic [TW-1:0] count_q;
    logic [TW-1:0] count_d;

    // End-of-phase detect; >= so a counter can never run past its limit.
    always_comb begin
        phase_end = (count_q >= dur);
    end

    // Next counter value: restart wins over hold, wrap to 1 at phase end.
    always_comb begin
        count_d = count_q;
        if (restart) begin
            count_d = {{(TW-1){1'b0}}, 1'b1};
        end else if (hold) begin
            count_d = count_q;
        end else if (phase_end) begin
            count_d = {{(TW-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q + {{(TW-1){1'b0}}, 1'b1};
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= {{(TW-1){1'b0}}, 1'b1};
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/tls_multi.sv
// -----------------------------------------------------------------------------
// tls_multi
// Multi-approach traffic-light sequencer. Rotates right-of-way across NUM_DIR
// approaches: GREEN -> YELLOW -> ALLRED -> next approach GREEN.
// Optional feature macro: TLS_PED_EN (pedestrian request / walk lamps).
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   set                 : latch g_in/y_in/ar_in, restart at approach 0 GREEN
//   stop                : freeze state, approach and counter
//   jump                : force current approach into all-red clearance
//   g_in, y_in, ar_in   : durations in cycles (TW bits each)
//   ped_req [NUM_DIR]   : (TLS_PED_EN) per-approach pedestrian request pulses
//   green/yellow/red    : per-approach lamp drives (registered)
//   walk [NUM_DIR]      : (TLS_PED_EN) per-approach walk lamps (registered)
//   dir                 : approach holding right-of-way
//   count               : 1-based phase counter
//   cycle_done          : one-cycle pulse when dir wraps to approach 0
// -----------------------------------------------------------------------------
module tls_multi
    import tls_pkg::*;
#(
    parameter int NUM_DIR = 2,
    parameter int TW      = 4,
    parameter int G_RST   = 8,
    parameter int Y_RST   = 2,
    parameter int AR_RST  = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       set,
    input  logic                       stop,
    input  logic                       jump,
    input  logic [TW-1:0]              g_in,
    input  logic [TW-1:0]              y_in,
    input  logic [TW-1:0]              ar_in,
`ifdef TLS_PED_EN
    input  logic [NUM_DIR-1:0]         ped_req,
    output logic [NUM_DIR-1:0]         walk,
`endif
    output logic [NUM_DIR-1:0]         green,
    output logic [NUM_DIR-1:0]         yellow,
    output logic [NUM_DIR-1:0]         red,
    output logic [$clog2(NUM_DIR)-1:0] dir,
    output logic [TW-1:0]              count,
    output logic                       cycle_done
);

    localparam int DW = $clog2(NUM_DIR);

    localparam logic [NUM_DIR-1:0] OH_FIRST = LAMP_FIRST[NUM_DIR-1:0];
    localparam logic [NUM_DIR-1:0] OH_NONE  = LAMP_NONE[NUM_DIR-1:0];
    localparam logic [NUM_DIR-1:0] OH_ALL   = LAMP_ALL[NUM_DIR-1:0];

    tls_state_e           state_q, state_d;
    logic [DW-1:0]        dir_q, dir_d;
    logic [TW-1:0]        g_q, g_d;
    logic [TW-1:0]        y_q, y_d;
    logic [TW-1:0]        ar_q, ar_d;
    logic [NUM_DIR-1:0]   green_q, green_d;
    logic [NUM_DIR-1:0]   yellow_q, yellow_d;
    logic [NUM_DIR-1:0]   red_q, red_d;
    logic                 cycle_done_q, cycle_done_d;

    logic                 wrap_s;
    logic [DW-1:0]        dir_nxt_s;
    logic [NUM_DIR-1:0]   oh_d_s;
    logic [TW-1:0]        dur_s;
    logic [TW-1:0]        count_s;
    logic                 phase_end_s;
    logic                 timer_restart_s;
    logic                 timer_hold_s;

    // Next approach index, modulo NUM_DIR.
    always_comb begin
        wrap_s = (dir_q == DW'(NUM_DIR - 1));
        if (wrap_s) begin
            dir_nxt_s = {DW{1'b0}};
        end else begin
            dir_nxt_s = dir_q + DW'(1);
        end
    end

    // Effective duration of the phase currently being timed.
    always_comb begin
        dur_s = TW'(eff_dur(state_q, DUR_W'(g_q), DUR_W'(y_q), DUR_W'(ar_q)));
    end

    tls_phase_timer #(
        .TW (TW)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .restart   (timer_restart_s),
        .hold      (timer_hold_s),
        .dur       (dur_s),
        .count     (count_s),
        .phase_end (phase_end_s)
    );

    // Sequencer next state: set > jump > stop > normal advance (rst in the flops).
    always_comb begin
        state_d         = state_q;
        dir_d           = dir_q;
        g_d             = g_q;
        y_d             = y_q;
        ar_d            = ar_q;
        cycle_done_d    = 1'b0;
        timer_restart_s = 1'b0;
        timer_hold_s    = 1'b0;

        if (set) begin
            g_d             = g_in;
            y_d             = y_in;
            ar_d            = ar_in;
            state_d         = ST_GREEN;
            dir_d           = {DW{1'b0}};
            timer_restart_s = 1'b1;
        end else if (jump && (state_q != ST_ALLRED)) begin
            timer_restart_s = 1'b1;
            if (ar_q == {TW{1'b0}}) begin
                state_d      = ST_GREEN;
                dir_d        = dir_nxt_s;
                cycle_done_d = wrap_s;
            end else begin
                state_d = ST_ALLRED;
            end
        end else if (stop && !jump) begin
            // jump in ALLRED is ignored but still overrides stop.
            timer_hold_s = 1'b1;
        end else if (phase_end_s) begin
            case (state_q)
                ST_GREEN: begin
                    state_d = ST_YELLOW;
                end
                ST_YELLOW: begin
                    if (ar_q == {TW{1'b0}}) begin
                        state_d      = ST_GREEN;
                        dir_d        = dir_nxt_s;
                        cycle_done_d = wrap_s;
                    end else begin
                        state_d = ST_ALLRED;
                    end
                end
                ST_ALLRED: begin
                    state_d      = ST_GREEN;
                    dir_d        = dir_nxt_s;
                    cycle_done_d = wrap_s;
                end
                default: begin
                    state_d = ST_GREEN;
                    dir_d   = {DW{1'b0}};
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Lamp decode from the next state so lamps are registered with it.
    always_comb begin
        oh_d_s = OH_FIRST << dir_d;
        if (state_d == ST_GREEN) begin
            green_d = oh_d_s;
        end else begin
            green_d = OH_NONE;
        end
        if (state_d == ST_YELLOW) begin
            yellow_d = oh_d_s;
        end else begin
            yellow_d = OH_NONE;
        end
        red_d = OH_ALL & ~(green_d | yellow_d);
    end

    // Sequencer, duration and lamp registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_GREEN;
            dir_q        <= {DW{1'b0}};
            g_q          <= TW'(G_RST);
            y_q          <= TW'(Y_RST);
            ar_q         <= TW'(AR_RST);
            green_q      <= OH_FIRST;
            yellow_q     <= OH_NONE;
            red_q        <= OH_ALL & ~OH_FIRST;
            cycle_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            dir_q        <= dir_d;
            g_q          <= g_d;
            y_q          <= y_d;
            ar_q         <= ar_d;
            green_q      <= green_d;
            yellow_q     <= yellow_d;
            red_q        <= red_d;
            cycle_done_q <= cycle_done_d;
        end
    end

`ifdef TLS_PED_EN
    logic [NUM_DIR-1:0] req_q, req_d;
    logic [NUM_DIR-1:0] walk_q, walk_d;
    logic               enter_green_s;

    // Pedestrian requests: the pending bit moves into walk when its approach's
    // GREEN starts, so requests raised during that GREEN wait for the next one.
    always_comb begin
        req_d         = req_q | ped_req;
        walk_d        = walk_q;
        enter_green_s = (state_d == ST_GREEN) &&
                        ((state_q != ST_GREEN) || (dir_d != dir_q));
        if (set) begin
            req_d  = OH_NONE;
            walk_d = OH_NONE;
        end else if (state_d != ST_GREEN) begin
            walk_d = OH_NONE;
        end else if (enter_green_s) begin
            walk_d = oh_d_s & req_d;
            req_d  = req_d & ~oh_d_s;
        end else begin
            walk_d = walk_q;
        end
    end

    // Pedestrian request and walk registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_q  <= OH_NONE;
            walk_q <= OH_NONE;
        end else begin
            req_q  <= req_d;
            walk_q <= walk_d;
        end
    end

    assign walk = walk_q;
`endif

    assign green      = green_q;
    assign yellow     = yellow_q;
    assign red        = red_q;
    assign dir        = dir_q;
    assign count      = count_s;
    assign cycle_done = cycle_done_q;

endmodule

// File: tb/tb_tls_multi.sv
// -----------------------------------------------------------------------------
// tb_tls_multi
// Self-checking bench for tls_multi (NUM_DIR=2, TW=4, defaults 8/2/1).
// A hand-derived vector table covers the sequencing corner cases; a randomised
// phase follows, with expectations from a small reference model. Expected
// records go to a scoreboard queue when driven and are compared on the next
// falling edge, after the DUT has clocked them in.
// -----------------------------------------------------------------------------
module tb_tls_multi;

    localparam int ND = 2;
    localparam int TW = 4;

    logic          clk;
    logic          rst, set, stop, jump;
    logic [TW-1:0] g_in, y_in, ar_in;
    logic [ND-1:0] green, yellow, red;
    logic [0:0]    dir;
    logic [TW-1:0] count;
    logic          cycle_done;
    logic [ND-1:0] ped_req;
    logic [ND-1:0] walk_s;
`ifdef TLS_PED_EN
    logic [ND-1:0] walk;
    assign walk_s = walk;
`else
    assign walk_s = 2'b00;
`endif

    tls_multi #(
        .NUM_DIR (ND),
        .TW      (TW),
        .G_RST   (8),
        .Y_RST   (2),
        .AR_RST  (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .set        (set),
        .stop       (stop),
        .jump       (jump),
        .g_in       (g_in),
        .y_in       (y_in),
        .ar_in      (ar_in),
`ifdef TLS_PED_EN
        .ped_req    (ped_req),
        .walk       (walk),
`endif
        .green      (green),
        .yellow     (yellow),
        .red        (red),
        .dir        (dir),
        .count      (count),
        .cycle_done (cycle_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // est: 0 = GREEN, 1 = YELLOW, 2 = ALLRED
    typedef struct {
        logic       r, s, p, j;
        int         g, y, ar;
        logic [1:0] ped;
        int         edir, est, ecnt;
        logic       ecd;
        logic [1:0] ewalk;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   vec_no   = 0;

    // reference model state
    int         m_st, m_dir, m_cnt, m_g, m_y, m_ar;
    logic       m_cd;
    logic [1:0] m_req, m_walk;

    task automatic add(input logic r, s, p, j, input int g, y, ar,
                       input logic [1:0] ped, input int edir, est, ecnt,
                       input logic ecd, input logic [1:0] ew);
        vec_t v;
        v.r = r; v.s = s; v.p = p; v.j = j;
        v.g = g; v.y = y; v.ar = ar; v.ped = ped;
        v.edir = edir; v.est = est; v.ecnt = ecnt; v.ecd = ecd; v.ewalk = ew;
        tbl.push_back(v);
    endtask

    // idle cycles where count runs c0..c1 in one phase
    task automatic run(input int edir, est, c0, c1, input logic [1:0] ew);
        for (int c = c0; c <= c1; c++) begin
            add(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 2'b00, edir, est, c, 1'b0, ew);
        end
    endtask

    task automatic compare_head();
        vec_t       e;
        logic [1:0] one, eg, ey, er;
        if (sb.size() > 0) begin
            e   = sb.pop_front();
            one = 2'b01;
            eg  = (e.est == 0) ? (one << e.edir) : 2'b00;
            ey  = (e.est == 1) ? (one << e.edir) : 2'b00;
            er  = ~(eg | ey);
            checks++;
            if (green !== eg || yellow !== ey || red !== er ||
                int'(dir) != e.edir || int'(count) != e.ecnt ||
                cycle_done !== e.ecd || walk_s !== e.ewalk) begin
                failures++;
                $display("FAIL vec%0d: got g=%b y=%b r=%b dir=%0d cnt=%0d cd=%b walk=%b; want g=%b y=%b r=%b dir=%0d cnt=%0d cd=%b walk=%b",
                         vec_no, green, yellow, red, dir, count, cycle_done, walk_s,
                         eg, ey, er, e.edir, e.ecnt, e.ecd, e.ewalk);
            end
            vec_no++;
        end
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk);
        compare_head();
        rst     = v.r;
        set     = v.s;
        stop    = v.p;
        jump    = v.j;
        g_in    = TW'(v.g);
        y_in    = TW'(v.y);
        ar_in   = TW'(v.ar);
        ped_req = v.ped;
        sb.push_back(v);
    endtask

    task automatic m_green_next();
        logic [1:0] oh;
        m_dir  = (m_dir + 1) % ND;
        m_cd   = (m_dir == 0);
        m_st   = 0;
        m_cnt  = 1;
        oh     = (m_dir == 0) ? 2'b01 : 2'b10;
        m_walk = oh & m_req;
        m_req  = m_req & ~oh;
    endtask

    task automatic model(inout vec_t v);
        int lim;
        m_cd = 1'b0;
        if (v.r || v.s) begin
            if (v.r) begin
                m_g = 8; m_y = 2; m_ar = 1;
            end else begin
                m_g = v.g; m_y = v.y; m_ar = v.ar;
            end
            m_st = 0; m_dir = 0; m_cnt = 1; m_req = 2'b00; m_walk = 2'b00;
        end else begin
            m_req = m_req | v.ped;
            if (v.j && m_st != 2) begin
                if (m_ar == 0) m_green_next();
                else begin m_st = 2; m_cnt = 1; end
            end else if (v.p && !v.j) begin
                m_cnt = m_cnt;
            end else begin
                if (m_st == 0)      lim = (m_g == 0) ? 1 : m_g;
                else if (m_st == 1) lim = (m_y == 0) ? 1 : m_y;
                else                lim = m_ar;
                if (m_cnt < lim) m_cnt++;
                else if (m_st == 0) begin m_st = 1; m_cnt = 1; end
                else if (m_st == 1 && m_ar != 0) begin m_st = 2; m_cnt = 1; end
                else m_green_next();
            end
            if (m_st != 0) m_walk = 2'b00;
        end
        v.edir = m_dir; v.est = m_st; v.ecnt = m_cnt; v.ecd = m_cd; v.ewalk = m_walk;
    endtask

    initial begin
        vec_t v;
        rst = 1'b1; set = 1'b0; stop = 1'b0; jump = 1'b0;
        g_in = '0; y_in = '0; ar_in = '0; ped_req = '0;

        // reset and a full default rotation
        add(1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 0, 2'b00);
        run(0, 0, 2, 8, 2'b00); run(0, 1, 1, 2, 2'b00); run(0, 2, 1, 1, 2'b00);
        run(1, 0, 1, 8, 2'b00); run(1, 1, 1, 2, 2'b00); run(1, 2, 1, 1, 2'b00);
        add(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 1, 2'b00);
        run(0, 0, 2, 2, 2'b00);
        // stop for 5 cycles at green count 2, then the remaining 6 cycles
        for (int i = 0; i < 5; i++) add(0, 0, 1, 0, 0, 0, 0, 2'b00, 0, 0, 2, 0, 2'b00);
        run(0, 0, 3, 8, 2'b00); run(0, 1, 1, 1, 2'b00);
        // set 3/1/0 mid-yellow: no all-red phase
        add(0, 1, 0, 0, 3, 1, 0, 2'b00, 0, 0, 1, 0, 2'b00);
        run(0, 0, 2, 3, 2'b00); run(0, 1, 1, 1, 2'b00);
        run(1, 0, 1, 3, 2'b00); run(1, 1, 1, 1, 2'b00);
        add(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 1, 2'b00);
        // set 5/2/2; jump with stop at green count 4
        add(0, 1, 0, 0, 5, 2, 2, 2'b00, 0, 0, 1, 0, 2'b00);
        run(0, 0, 2, 4, 2'b00);
        add(0, 0, 1, 1, 0, 0, 0, 2'b00, 0, 2, 1, 0, 2'b00);
        run(0, 2, 2, 2, 2'b00); run(1, 0, 1, 1, 2'b00);
        add(0, 0, 0, 1, 0, 0, 0, 2'b00, 1, 2, 1, 0, 2'b00);
        // jump inside all-red is ignored, also overriding stop
        add(0, 0, 0, 1, 0, 0, 0, 2'b00, 1, 2, 2, 0, 2'b00);
        add(0, 0, 1, 1, 0, 0, 0, 2'b00, 0, 0, 1, 1, 2'b00);
        run(0, 0, 2, 5, 2'b00); run(0, 1, 1, 1, 2'b00);
        add(0, 0, 0, 1, 0, 0, 0, 2'b00, 0, 2, 1, 0, 2'b00);
        run(0, 2, 2, 2, 2'b00); run(1, 0, 1, 1, 2'b00);
        // jump with ar=0 goes straight to the next green, wrap pulses
        add(0, 1, 0, 0, 4, 1, 0, 2'b00, 0, 0, 1, 0, 2'b00);
        add(0, 0, 0, 1, 0, 0, 0, 2'b00, 1, 0, 1, 0, 2'b00);
        add(0, 0, 0, 1, 0, 0, 0, 2'b00, 0, 0, 1, 1, 2'b00);
        // zero durations: 1-cycle green/yellow, no all-red
        add(0, 1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 0, 2'b00);
        run(0, 1, 1, 1, 2'b00); run(1, 0, 1, 1, 2'b00); run(1, 1, 1, 1, 2'b00);
        add(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 1, 2'b00);
        run(0, 1, 1, 1, 2'b00);
        // rst beats set; set beats jump and stop
        add(1, 1, 0, 0, 2, 1, 1, 2'b00, 0, 0, 1, 0, 2'b00);
        run(0, 0, 2, 2, 2'b00);
        add(0, 1, 1, 1, 2, 1, 1, 2'b00, 0, 0, 1, 0, 2'b00);
        run(0, 0, 2, 2, 2'b00); run(0, 1, 1, 1, 2'b00); run(0, 2, 1, 1, 2'b00);
        run(1, 0, 1, 1, 2'b00);
`ifdef TLS_PED_EN
        // both requests during approach 0 green
        add(1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 0, 2'b00);
        add(0, 0, 0, 0, 0, 0, 0, 2'b11, 0, 0, 2, 0, 2'b00);
        run(0, 0, 3, 8, 2'b00); run(0, 1, 1, 2, 2'b00); run(0, 2, 1, 1, 2'b00);
        run(1, 0, 1, 8, 2'b10); run(1, 1, 1, 2, 2'b00); run(1, 2, 1, 1, 2'b00);
        add(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 1, 2'b01);
        run(0, 0, 2, 8, 2'b01); run(0, 1, 1, 1, 2'b00);
`endif
        for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

        // randomised phase checked against the model
        v = '{r: 1'b1, s: 1'b0, p: 1'b0, j: 1'b0, g: 0, y: 0, ar: 0,
              ped: 2'b00, edir: 0, est: 0, ecnt: 0, ecd: 1'b0, ewalk: 2'b00};
        model(v);
        apply(v);
        for (int i = 0; i < 600; i++) begin
            v.r   = ($urandom_range(0, 299) == 0);
            v.s   = ($urandom_range(0, 49) == 0);
            v.j   = ($urandom_range(0, 24) == 0);
            v.p   = ($urandom_range(0, 9) == 0);
            v.g   = $urandom_range(0, 6);
            v.y   = $urandom_range(0, 3);
            v.ar  = $urandom_range(0, 2);
`ifdef TLS_PED_EN
            v.ped = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
`else
            v.ped = 2'b00;
`endif
            model(v);
            apply(v);
        end
        @(negedge clk);
        compare_head();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
